// File: rtl/misaligned_load_unit_pkg.sv
// Load-mode and FSM-state encodings shared by the misaligned load unit,
// plus helpers giving the access width and signedness of each load mode.
package misaligned_load_unit_pkg;

  typedef enum logic [2:0] {
    LM_NOREG = 3'd0,
    LM_LB    = 3'd1,
    LM_LH    = 3'd2,
    LM_LW    = 3'd3,
    LM_LBU   = 3'd4,
    LM_LHU   = 3'd5,
    LM_LWU   = 3'd6,
    LM_LD    = 3'd7
  } load_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  // Access width in bytes; 0 means no register write (incl. RV64-only modes on RV32).
  function automatic logic [3:0] mode_size(input logic [2:0] mode, input int xlen);
    logic [3:0] sz;
    sz = 4'd0;
    case (mode)
      LM_LB, LM_LBU: sz = 4'd1;
      LM_LH, LM_LHU: sz = 4'd2;
      LM_LW:         sz = 4'd4;
      LM_LWU:        sz = (xlen == 64) ? 4'd4 : 4'd0;
      LM_LD:         sz = (xlen == 64) ? 4'd8 : 4'd0;
      default:       sz = 4'd0;
    endcase
    return sz;
  endfunction

  function automatic logic mode_signed(input logic [2:0] mode);
    return (mode == LM_LB) || (mode == LM_LH) || (mode == LM_LW) || (mode == LM_LD);
  endfunction

endpackage

// File: rtl/misaligned_load_unit_load_extend.sv
// Byte-align two adjacent words, keep the low size bytes, sign- or zero-extend.
// Purely combinational, no handshake.
module misaligned_load_unit_load_extend #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]             hi_i,
  input  logic [XLEN-1:0]             lo_i,
  input  logic [$clog2(XLEN/8)-1:0]   off_i,
  input  logic [3:0]                  size_i,
  input  logic                        sgn_i,
  output logic [XLEN-1:0]             data_o
);

  logic [XLEN-1:0] low;
  logic            fill;

  always_comb begin
    low = XLEN'({hi_i, lo_i} >> {off_i, 3'b000});
    case (size_i)
      4'd1:    fill = sgn_i & low[7];
      4'd2:    fill = sgn_i & low[15];
      4'd4:    fill = sgn_i & low[31];
      default: fill = 1'b0;
    endcase
    data_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      data_o[i] = (i < 8 * int'(size_i)) ? low[i] : fill;
    end
  end

endmodule

// File: rtl/misaligned_load_unit.sv
// Load unit reading word-addressed memory, splitting word-crossing loads in two reads.
// Response 3 cycles after accept (4 if split); result held until RespReady, one request at a time.
module misaligned_load_unit
  import misaligned_load_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int AW               = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                           CPU_CLK,
  input  logic                           CPU_RST_N,
  input  logic                           Flush,
  input  logic                           ReqValid,
  output logic                           ReqReady,
  input  logic [AW-1:0]                  ReqAddr,
  input  logic [2:0]                     ReqMode,
  output logic                           MemRdEn,
  output logic [AW-$clog2(XLEN/8)-1:0]   MemAddr,
  input  logic [XLEN-1:0]                MemRdata,
  output logic                           RespValid,
  input  logic                           RespReady,
  output logic [XLEN-1:0]                RespData,
  output logic                           RespFault
);

  localparam int BPW  = XLEN / 8;
  localparam int OFFW = $clog2(BPW);
  localparam int WAW  = AW - OFFW;

  lsu_state_e      state_q, state_d;
  logic [2:0]      mode_q, mode_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [WAW-1:0]  waddr_q, waddr_d;
  logic            split_q, split_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            fault_q, fault_d;

  logic [3:0]      req_size;
  logic [OFFW-1:0] req_off;
  logic            req_split;
  logic [XLEN-1:0] ext_hi, ext_lo, ext_data;

  // In WAIT the memory returns either the only word or the upper half of a split pair.
  assign ext_hi = split_q ? MemRdata : '0;
  assign ext_lo = split_q ? lo_q : MemRdata;

  misaligned_load_unit_load_extend #(
    .XLEN (XLEN)
  ) u_extend (
    .hi_i   (ext_hi),
    .lo_i   (ext_lo),
    .off_i  (off_q),
    .size_i (mode_size(mode_q, XLEN)),
    .sgn_i  (mode_signed(mode_q)),
    .data_o (ext_data)
  );

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      state_q <= ST_IDLE;
      mode_q  <= 3'd0;
      off_q   <= '0;
      waddr_q <= '0;
      split_q <= 1'b0;
      lo_q    <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      split_q <= split_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    off_d     = off_q;
    waddr_d   = waddr_q;
    split_d   = split_q;
    lo_d      = lo_q;
    data_d    = data_q;
    fault_d   = fault_q;
    ReqReady  = 1'b0;
    MemRdEn   = 1'b0;
    MemAddr   = '0;
    req_size  = mode_size(ReqMode, XLEN);
    req_off   = ReqAddr[OFFW-1:0];
    req_split = (int'(req_off) + int'(req_size)) > BPW;

    unique case (state_q)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          mode_d  = ReqMode;
          off_d   = req_off;
          waddr_d = ReqAddr[AW-1:OFFW];
          split_d = req_split;
          data_d  = '0;
          fault_d = 1'b0;
          if (req_size == 4'd0) begin
            state_d = ST_RESP;
          end else if (req_split && !ALLOW_MISALIGNED) begin
            state_d = ST_RESP;
            fault_d = 1'b1;
          end else begin
            state_d = ST_RD0;
          end
        end
      end
      ST_RD0: begin
        MemRdEn = 1'b1;
        MemAddr = waddr_q;
        state_d = split_q ? ST_RD1 : ST_WAIT;
      end
      ST_RD1: begin
        MemRdEn = 1'b1;
        MemAddr = waddr_q + WAW'(1);
        lo_d    = MemRdata;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        data_d  = ext_data;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (RespReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (Flush) begin
      state_d = ST_IDLE;
      data_d  = '0;
      fault_d = 1'b0;
    end
  end

  assign RespValid = (state_q == ST_RESP);
  assign RespData  = data_q;
  assign RespFault = fault_q;

endmodule

// File: tb/tb_misaligned_load_unit.sv
// Directed bench: RV32 unit with and without misaligned support plus an RV64 unit, sharing stimulus.
module tb_misaligned_load_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, req_vld, resp_rdy;
  logic [31:0] req_addr;
  logic [2:0]  req_mode;

  logic        a_req_rdy, a_rd_en, a_resp_vld, a_fault;
  logic [29:0] a_maddr;
  logic [31:0] a_rdata, a_resp;
  logic        f_req_rdy, f_rd_en, f_resp_vld, f_fault;
  logic [29:0] f_maddr;
  logic [31:0] f_rdata, f_resp;
  logic        d_req_rdy, d_rd_en, d_resp_vld, d_fault;
  logic [28:0] d_maddr;
  logic [63:0] d_rdata, d_resp;

  int passed = 0;
  int total  = 0;
  int lat_a, lat_f, lat_d, rd_a, rd_f, rc0, rc1;
  logic [29:0] ad0, ad1;
  logic [31:0] dat_a, dat_f;
  logic [63:0] dat_d;
  logic        flt_f;

  misaligned_load_unit #(.XLEN(32), .AW(32), .ALLOW_MISALIGNED(1'b1)) u_a (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .Flush(flush), .ReqValid(req_vld), .ReqReady(a_req_rdy),
    .ReqAddr(req_addr), .ReqMode(req_mode), .MemRdEn(a_rd_en), .MemAddr(a_maddr),
    .MemRdata(a_rdata), .RespValid(a_resp_vld), .RespReady(resp_rdy), .RespData(a_resp),
    .RespFault(a_fault));

  misaligned_load_unit #(.XLEN(32), .AW(32), .ALLOW_MISALIGNED(1'b0)) u_f (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .Flush(flush), .ReqValid(req_vld), .ReqReady(f_req_rdy),
    .ReqAddr(req_addr), .ReqMode(req_mode), .MemRdEn(f_rd_en), .MemAddr(f_maddr),
    .MemRdata(f_rdata), .RespValid(f_resp_vld), .RespReady(resp_rdy), .RespData(f_resp),
    .RespFault(f_fault));

  misaligned_load_unit #(.XLEN(64), .AW(32), .ALLOW_MISALIGNED(1'b1)) u_d (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .Flush(flush), .ReqValid(req_vld), .ReqReady(d_req_rdy),
    .ReqAddr(req_addr), .ReqMode(req_mode), .MemRdEn(d_rd_en), .MemAddr(d_maddr),
    .MemRdata(d_rdata), .RespValid(d_resp_vld), .RespReady(resp_rdy), .RespData(d_resp),
    .RespFault(d_fault));

  function automatic logic [31:0] mem32(input logic [29:0] w);
    if (w == 30'h40) return 32'hDDCCBBAA;
    if (w == 30'h41) return 32'h44332211;
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (a_rd_en) a_rdata <= mem32(a_maddr);
    if (f_rd_en) f_rdata <= mem32(f_maddr);
    if (d_rd_en) d_rdata <= (d_maddr == 29'h0) ? 64'h8877665544332211 : 64'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request in the current cycle T, then watch 8 cycles with RespReady low.
  task automatic do_req(input logic [31:0] addr, input logic [2:0] mode);
    req_addr = addr;
    req_mode = mode;
    req_vld  = 1'b1;
    resp_rdy = 1'b0;
    lat_a = -1; lat_f = -1; lat_d = -1;
    rd_a = 0; rd_f = 0; rc0 = -1; rc1 = -1;
    ad0 = '0; ad1 = '0;
    dat_a = '0; dat_f = '0; dat_d = '0; flt_f = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) req_vld = 1'b0;
      if (a_rd_en) begin
        rd_a++;
        if (rd_a == 1) begin ad0 = a_maddr; rc0 = c; end
        else begin ad1 = a_maddr; rc1 = c; end
      end
      if (f_rd_en) rd_f++;
      if (a_resp_vld && lat_a < 0) begin lat_a = c; dat_a = a_resp; end
      if (f_resp_vld && lat_f < 0) begin lat_f = c; dat_f = f_resp; flt_f = f_fault; end
      if (d_resp_vld && lat_d < 0) begin lat_d = c; dat_d = d_resp; end
    end
  endtask

  task automatic handshake();
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_vld = 1'b0; resp_rdy = 1'b0;
    req_addr = '0; req_mode = 3'd0;
    step();
    step();
    total++; if (a_resp_vld !== 1'b0) $display("FAIL rst_resp_vld: got %b want 0", a_resp_vld); else passed++;
    total++; if (a_resp !== 32'h0) $display("FAIL rst_resp_data: got %h want 0", a_resp); else passed++;
    total++; if (a_fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", a_fault); else passed++;
    total++; if (a_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", a_rd_en); else passed++;
    total++; if (a_maddr !== 30'h0) $display("FAIL rst_maddr: got %h want 0", a_maddr); else passed++;
    rst_n = 1'b1;
    step();
    total++; if (a_req_rdy !== 1'b1) $display("FAIL rst_req_rdy: got %b want 1", a_req_rdy); else passed++;
  endtask

  task automatic test_lb_aligned();
    do_req(32'h103, 3'd1);
    total++; if (lat_a !== 3) $display("FAIL lb_latency: got %0d want 3", lat_a); else passed++;
    total++; if (dat_a !== 32'hFFFFFFDD) $display("FAIL lb_data: got %h want ffffffdd", dat_a); else passed++;
    total++; if (rd_a !== 1) $display("FAIL lb_reads: got %0d want 1", rd_a); else passed++;
    total++; if (ad0 !== 30'h40) $display("FAIL lb_addr: got %h want 40", ad0); else passed++;
    total++; if (lat_f !== 3) $display("FAIL lb_nomis_latency: got %0d want 3", lat_f); else passed++;
    handshake();
    total++; if (a_req_rdy !== 1'b1) $display("FAIL lb_idle_after: got %b want 1", a_req_rdy); else passed++;
  endtask

  task automatic test_split_lhu();
    do_req(32'h103, 3'd5);
    total++; if (lat_a !== 4) $display("FAIL lhu_latency: got %0d want 4", lat_a); else passed++;
    total++; if (dat_a !== 32'h000011DD) $display("FAIL lhu_data: got %h want 000011dd", dat_a); else passed++;
    total++; if (rd_a !== 2) $display("FAIL lhu_reads: got %0d want 2", rd_a); else passed++;
    total++; if (ad0 !== 30'h40) $display("FAIL lhu_addr0: got %h want 40", ad0); else passed++;
    total++; if (ad1 !== 30'h41) $display("FAIL lhu_addr1: got %h want 41", ad1); else passed++;
    total++; if (rc1 !== rc0 + 1) $display("FAIL lhu_consecutive: got cycles %0d,%0d want adjacent", rc0, rc1); else passed++;
    total++; if (flt_f !== 1'b1) $display("FAIL lhu_fault: got %b want 1", flt_f); else passed++;
    handshake();
  endtask

  task automatic test_split_lw();
    do_req(32'h102, 3'd3);
    total++; if (lat_a !== 4) $display("FAIL lw_latency: got %0d want 4", lat_a); else passed++;
    total++; if (dat_a !== 32'h2211DDCC) $display("FAIL lw_data: got %h want 2211ddcc", dat_a); else passed++;
    total++; if (lat_f !== 1) $display("FAIL lw_fault_latency: got %0d want 1", lat_f); else passed++;
    total++; if (flt_f !== 1'b1) $display("FAIL lw_fault: got %b want 1", flt_f); else passed++;
    total++; if (dat_f !== 32'h0) $display("FAIL lw_fault_data: got %h want 0", dat_f); else passed++;
    total++; if (rd_f !== 0) $display("FAIL lw_fault_reads: got %0d want 0", rd_f); else passed++;
    handshake();
  endtask

  task automatic test_hold();
    do_req(32'h101, 3'd2);
    total++; if (lat_a !== 3) $display("FAIL lh_latency: got %0d want 3", lat_a); else passed++;
    total++; if (dat_a !== 32'hFFFFCCBB) $display("FAIL lh_data: got %h want ffffccbb", dat_a); else passed++;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (a_resp_vld !== 1'b1) $display("FAIL hold_vld[%0d]: got %b want 1", k, a_resp_vld); else passed++;
      total++; if (a_resp !== 32'hFFFFCCBB) $display("FAIL hold_data[%0d]: got %h want ffffccbb", k, a_resp); else passed++;
      total++; if (a_req_rdy !== 1'b0) $display("FAIL hold_req_rdy[%0d]: got %b want 0", k, a_req_rdy); else passed++;
    end
    handshake();
    total++; if (a_resp_vld !== 1'b0) $display("FAIL hold_release: got %b want 0", a_resp_vld); else passed++;
  endtask

  task automatic test_flush();
    req_addr = 32'h102; req_mode = 3'd3; req_vld = 1'b1;
    step();
    req_vld = 1'b0;
    total++; if (a_rd_en !== 1'b1 || a_maddr !== 30'h40) $display("FAIL flush_rd0: got en=%b addr=%h want 1/40", a_rd_en, a_maddr); else passed++;
    step();
    total++; if (a_rd_en !== 1'b1 || a_maddr !== 30'h41) $display("FAIL flush_rd1: got en=%b addr=%h want 1/41", a_rd_en, a_maddr); else passed++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (a_req_rdy !== 1'b1) $display("FAIL flush_idle: got %b want 1", a_req_rdy); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++; if (a_resp_vld !== 1'b0) $display("FAIL flush_no_resp[%0d]: got %b want 0", k, a_resp_vld); else passed++;
      step();
    end
  endtask

  task automatic test_reset_wait();
    req_addr = 32'h102; req_mode = 3'd3; req_vld = 1'b1;
    step();
    req_vld = 1'b0;
    step();
    step();
    total++; if (f_fault !== 1'b1) $display("FAIL rstw_pre_fault: got %b want 1", f_fault); else passed++;
    rst_n = 1'b0;
    step();
    total++; if (a_resp_vld !== 1'b0) $display("FAIL rstw_vld: got %b want 0", a_resp_vld); else passed++;
    total++; if (a_rd_en !== 1'b0 || a_maddr !== 30'h0) $display("FAIL rstw_mem: got en=%b addr=%h want 0/0", a_rd_en, a_maddr); else passed++;
    total++; if (a_resp !== 32'h0) $display("FAIL rstw_data: got %h want 0", a_resp); else passed++;
    total++; if (f_fault !== 1'b0 || f_resp_vld !== 1'b0) $display("FAIL rstw_fault: got flt=%b vld=%b want 0/0", f_fault, f_resp_vld); else passed++;
    rst_n = 1'b1;
    step();
    step();
    total++; if (a_resp_vld !== 1'b0) $display("FAIL rstw_stays_idle: got %b want 0", a_resp_vld); else passed++;
  endtask

  task automatic test_xlen64();
    do_req(32'h0, 3'd7);
    total++; if (lat_d !== 3) $display("FAIL ld_latency: got %0d want 3", lat_d); else passed++;
    total++; if (dat_d !== 64'h8877665544332211) $display("FAIL ld_data: got %h want 8877665544332211", dat_d); else passed++;
    total++; if (lat_a !== 1 || dat_a !== 32'h0 || rd_a !== 0) $display("FAIL ld_on_rv32: got lat=%0d data=%h reads=%0d want 1/0/0", lat_a, dat_a, rd_a); else passed++;
    handshake();
    do_req(32'h4, 3'd6);
    total++; if (dat_d !== 64'h0000000088776655) $display("FAIL lwu_data: got %h want 0000000088776655", dat_d); else passed++;
    handshake();
    do_req(32'h4, 3'd3);
    total++; if (dat_d !== 64'hFFFFFFFF88776655) $display("FAIL lw64_data: got %h want ffffffff88776655", dat_d); else passed++;
    handshake();
  endtask

  initial begin
    test_reset();
    test_lb_aligned();
    test_split_lhu();
    test_split_lw();
    test_hold();
    test_flush();
    test_reset_wait();
    test_xlen64();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
